// File: rtl/inst_queue_pkg.sv
// Shared CPU types used by the fetch/decode boundary, plus the
// instruction-queue entry layout and a small slot-count helper.
package inst_queue_pkg;

  // Virtual address and raw instruction word.
  typedef logic [31:0] virt_t;
  typedef logic [31:0] uint32_t;

  // Fetch-stage exception: valid flag plus cause code, carried untouched.
  typedef struct packed {
    logic       valid;
    logic [4:0] cause;
  } exception_t;

  // One queued instruction as it travels from fetch to decode.
  typedef struct packed {
    virt_t      pc;
    uint32_t    inst;
    exception_t exception;
  } inst_queue_entry_t;

  // Number of fetch/decode lanes.
  localparam int unsigned SLOTS = 2;

  // Count the leading run of set bits in a two-lane mask. Lane 1 only
  // counts when lane 0 is set, so the illegal pattern 2'b10 yields zero.
  function automatic logic [1:0] slot_count(input logic [1:0] mask);
    logic [1:0] n;
    unique case (mask)
      2'b01:   n = 2'd1;
      2'b11:   n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Two-wide in-order instruction queue between fetch and decode.
// Circular buffer of DEPTH entries; up to two pushes and two pops per
// cycle, flush on pipeline redirect, no write-to-read bypass.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic       [1:0]         in_valid,
  input  virt_t      [1:0]         in_pc,
  input  uint32_t    [1:0]         in_inst,
  input  exception_t [1:0]         in_exception,
  output logic                     in_ready,
  output logic       [1:0]         out_valid,
  output virt_t      [1:0]         out_pc,
  output uint32_t    [1:0]         out_inst,
  output exception_t [1:0]         out_exception,
  input  logic       [1:0]         out_accept,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // in_ready threshold: room for a full two-wide push.
  localparam logic [CNT_W-1:0] READY_LIMIT = CNT_W'(DEPTH - 2);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("inst_queue: DEPTH must be a power of two and at least 4");
  end

  inst_queue_entry_t mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [PTR_W-1:0] head_next;
  logic [PTR_W-1:0] tail_next;
  logic [CNT_W-1:0] count_next;
  logic [1:0]       push_n;
  logic [1:0]       pop_n;

  inst_queue_entry_t head_entry;
  inst_queue_entry_t next_entry;

  // Handshake status derived only from the registered occupancy.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    in_ready     = 1'b0;
    out_valid    = 2'b00;
    in_ready     = (count <= READY_LIMIT);
    out_valid[0] = (count >= CNT_W'(1));
    out_valid[1] = (count >= CNT_W'(2));
  end

  // Push/pop amounts and next pointer/occupancy values.
  always_comb begin
    push_n     = in_ready ? slot_count(in_valid) : 2'd0;
    pop_n      = slot_count(out_accept & out_valid);
    head_p1    = head + PTR_W'(1);
    tail_p1    = tail + PTR_W'(1);
    head_next  = head + PTR_W'(pop_n);
    tail_next  = tail + PTR_W'(push_n);
    count_next = count + CNT_W'(push_n) - CNT_W'(pop_n);
  end

  // Pointer and occupancy registers; flush empties the queue and drops
  // any push or pop presented in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
  end

  // Entry storage: slot 0 lands at tail, slot 1 at tail+1.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; validity comes solely from the reset pointers and count.
    if (!flush && push_n != 2'd0) begin
      mem[tail] <= '{pc: in_pc[0], inst: in_inst[0], exception: in_exception[0]};
    end
    if (!flush && push_n == 2'd2) begin
      mem[tail_p1] <= '{pc: in_pc[1], inst: in_inst[1], exception: in_exception[1]};
    end
  end

  // Present the two oldest entries to decode.
  always_comb begin
    head_entry       = mem[head];
    next_entry       = mem[head_p1];
    out_pc[0]        = head_entry.pc;
    out_inst[0]      = head_entry.inst;
    out_exception[0] = head_entry.exception;
    out_pc[1]        = next_entry.pc;
    out_inst[1]      = next_entry.inst;
    out_exception[1] = next_entry.exception;
  end

  // Occupancy can never exceed capacity.
  a_count_bound: assert property (@(posedge clk) disable iff (!resetn)
    count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: the stimulus task queues the entries
// it expects the DUT to accept; a negedge monitor checks occupancy and
// handshakes every cycle and pops/compares each entry decode consumes.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              clk;
  logic              resetn;
  logic              flush;
  logic [1:0]        in_valid;
  virt_t      [1:0]  in_pc;
  uint32_t    [1:0]  in_inst;
  exception_t [1:0]  in_exception;
  logic              in_ready;
  logic [1:0]        out_valid;
  virt_t      [1:0]  out_pc;
  uint32_t    [1:0]  out_inst;
  exception_t [1:0]  out_exception;
  logic [1:0]        out_accept;
  logic [CNT_W-1:0]  count;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_pc        (in_pc),
    .in_inst      (in_inst),
    .in_exception (in_exception),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_exception(out_exception),
    .out_accept   (out_accept),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  inst_queue_entry_t sb_q[$];
  int                cur_count   = 0;  // occupancy the DUT should show this cycle
  int                model_count = 0;  // occupancy after this cycle's edge
  virt_t             next_pc     = 32'hBFC0_0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic inst_queue_entry_t mk(input virt_t pc, input exception_t e);
    inst_queue_entry_t r;
    r.pc        = pc;
    r.inst      = pc ^ 32'hA5A5_3C3C;
    r.exception = e;
    return r;
  endfunction

  // One cycle of stimulus; queues the entries expected to be accepted.
  task automatic step(input logic fl, input logic [1:0] v, input logic [1:0] acc,
                      input exception_t e1 = '0);
    inst_queue_entry_t s0, s1;
    int  npush, npop;
    bit  exp_ready, p0, p1;
    @(posedge clk);
    #1;
    s0 = mk(next_pc, '0);
    s1 = mk(next_pc + 32'd4, e1);
    flush           = fl;
    in_valid        = v;
    in_pc[0]        = s0.pc;
    in_inst[0]      = s0.inst;
    in_exception[0] = s0.exception;
    in_pc[1]        = s1.pc;
    in_inst[1]      = s1.inst;
    in_exception[1] = s1.exception;
    out_accept      = acc;
    cur_count       = model_count;
    exp_ready = (model_count <= int'(DEPTH) - 2);
    npush = 0;
    if (!fl && exp_ready) npush = (v == 2'b11) ? 2 : ((v == 2'b01) ? 1 : 0);
    p0   = acc[0] && (model_count >= 1);
    p1   = p0 && acc[1] && (model_count >= 2);
    npop = int'(p0) + int'(p1);
    if (fl) begin
      sb_q.delete();
      model_count = 0;
    end else begin
      if (npush >= 1) sb_q.push_back(s0);
      if (npush == 2) sb_q.push_back(s1);
      model_count = model_count + npush - npop;
    end
    next_pc = next_pc + virt_t'(4 * npush);
  endtask

  // Asynchronous reset pulse in the middle of a cycle.
  task automatic reset_pulse();
    @(posedge clk);
    #1;
    flush      = 1'b0;
    in_valid   = 2'b00;
    out_accept = 2'b00;
    #1;
    resetn = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 2'b00);
    check("rst_in_ready", in_ready, 1'b1);
    sb_q.delete();
    model_count = 0;
    cur_count   = 0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Monitor: occupancy/handshake every cycle, entry compare per pop.
  always @(negedge clk) begin
    bit a0, a1;
    inst_queue_entry_t e;
    check("count", count, 64'(cur_count));
    check("in_ready", in_ready, 64'(cur_count <= int'(DEPTH) - 2));
    check("out_valid", out_valid, {62'd0, (cur_count >= 2), (cur_count >= 1)});
    a0 = resetn && !flush && out_accept[0] && (cur_count >= 1);
    a1 = a0 && out_accept[1] && (cur_count >= 2);
    for (int i = 0; i < 2; i++) begin
      if ((i == 0 && a0) || (i == 1 && a1)) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop%0d_scoreboard_empty actual=empty required=entry", i);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("pop%0d_pc", i), out_pc[i], e.pc);
          check($sformatf("pop%0d_inst", i), out_inst[i], e.inst);
          check($sformatf("pop%0d_exc", i), out_exception[i], e.exception);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    resetn       = 1'b0;
    flush        = 1'b0;
    in_valid     = 2'b00;
    in_pc        = '0;
    in_inst      = '0;
    in_exception = '0;
    out_accept   = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Two-wide push after reset, then consume both.
    step(1'b0, 2'b11, 2'b00);
    step(1'b0, 2'b00, 2'b11);

    // Illegal 2'b10 push ignored; accept bits on an empty queue ignored.
    step(1'b0, 2'b10, 2'b00);
    step(1'b0, 2'b01, 2'b11);
    step(1'b0, 2'b00, 2'b10);
    step(1'b0, 2'b00, 2'b01);

    // Fill to capacity, attempt further pushes, then drain.
    repeat (4) step(1'b0, 2'b11, 2'b00);
    step(1'b0, 2'b11, 2'b00);
    step(1'b0, 2'b01, 2'b00);
    repeat (4) step(1'b0, 2'b00, 2'b11);

    // Simultaneous push and pop at count=1.
    step(1'b0, 2'b01, 2'b00);
    step(1'b0, 2'b11, 2'b01);
    step(1'b0, 2'b00, 2'b11);

    // count=6: push 2 / accept 1, then push 2 / accept 2 at count=6.
    repeat (3) step(1'b0, 2'b11, 2'b00);
    step(1'b0, 2'b11, 2'b01);
    step(1'b0, 2'b00, 2'b01);
    step(1'b0, 2'b11, 2'b11);
    repeat (3) step(1'b0, 2'b00, 2'b11);

    // Steady streaming across pointer wrap.
    step(1'b0, 2'b11, 2'b00);
    repeat (20) step(1'b0, 2'b11, 2'b11);
    step(1'b0, 2'b00, 2'b11);

    // Flush at count=5 with a concurrent push and accept.
    step(1'b0, 2'b11, 2'b00);
    step(1'b0, 2'b11, 2'b00);
    step(1'b0, 2'b01, 2'b00);
    step(1'b1, 2'b11, 2'b11);
    step(1'b0, 2'b11, 2'b00);
    step(1'b0, 2'b00, 2'b11);

    // Exception on slot 1 travels with its PC.
    step(1'b0, 2'b11, 2'b00, '{valid: 1'b1, cause: 5'd12});
    step(1'b0, 2'b00, 2'b11);

    // Reset pulsed mid-stream, then normal operation resumes.
    step(1'b0, 2'b11, 2'b00);
    step(1'b0, 2'b11, 2'b01);
    reset_pulse();
    step(1'b0, 2'b11, 2'b00);
    step(1'b0, 2'b00, 2'b11);
    step(1'b0, 2'b00, 2'b00);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue capacity in entries; SHALL be a power of two, >= 4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  discard all queued and in-flight entries (pipeline redirect).
REQ-005 in_valid  input  2  fetch slot valid; in_valid[1] SHALL only be set when in_valid[0] is set.
REQ-006 in_pc  input  virt_t x2  fetch slot PCs.
REQ-007 in_inst  input  uint32_t x2  fetch slot instruction words.
REQ-008 in_exception  input  exception_t x2  fetch-stage exception per slot.
REQ-009 in_ready  output  1  queue can accept two entries this cycle.
REQ-010 out_valid  output  2  decode slot valid, in-order: out_valid[1] implies out_valid[0].
REQ-011 out_pc  output  virt_t x2  oldest and second-oldest entry PCs.
REQ-012 out_inst  output  uint32_t x2  oldest and second-oldest instruction words.
REQ-013 out_exception  output  exception_t x2  exceptions carried with each entry, unmodified.
REQ-014 out_accept  input  2  decoder consumes slots; out_accept[1] implies out_accept[0].
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 Entry SHALL hold {pc, inst, exception}; storage is a circular buffer with head (read) and tail (write) pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-017 in_ready SHALL equal (count <= DEPTH-2), from registered count only (no combinational path from out_accept).
REQ-018 Push count = in_valid[0]+in_valid[1] when in_ready=1, else 0; slot 0 written at tail, slot 1 at tail+1, tail advances by push count.
REQ-019 out_valid[0] = (count>=1), out_valid[1] = (count>=2); out slot 0 reads head, slot 1 reads head+1 (wrapped).
REQ-020 Pop count = out_accept bits that are also out_valid, in order; accept bits on invalid slots SHALL be ignored; head advances by pop count.
REQ-021 count_next = count + push - pop; SHALL never exceed DEPTH nor go below 0.
REQ-022 Latency: pushed entry SHALL appear on out_* no earlier than the next cycle (no bypass).
REQ-023 Simultaneous push and pop in one cycle SHALL both take effect, including when count=DEPTH-2 or count=1.
REQ-024 flush=1: next-cycle head=tail=0, count=0, out_valid=0; same-cycle push and pop SHALL be discarded.
REQ-025 Pushes with in_valid=2'b10 (illegal) SHALL be treated as no push.
REQ-026 out_pc/out_inst/out_exception are don't-care when the matching out_valid is 0.

Reset
REQ-027 resetn low SHALL asynchronously clear head, tail, count to 0; outputs: out_valid=0, in_ready=1, count=0.
REQ-028 Storage array SHALL NOT be reset; release of resetn mid-operation SHALL leave queue empty.

Structure
REQ-029 virt_t, uint32_t, exception_t SHALL come from the shared cpu package header; a queue entry struct type (inst_queue_entry_t) SHALL be added there.
REQ-030 Single module, no sub-module; storage inferred as flop array.

Verification
REQ-031 Reset then push pc 0xBFC00000/0xBFC00004 both valid -> next cycle out_valid=2'b11, count=2, out_pc matches, in_ready=1.
REQ-032 Fill DEPTH=8 with 4 two-wide pushes, no accept -> count=8, in_ready=0; further in_valid ignored, contents unchanged.
REQ-033 count=6, push 2 and accept 2'b01 same cycle -> count=7, head+1, oldest now former second entry.
REQ-034 Wrap: 20 cycles of push 2 / accept 2 -> PC sequence contiguous +4 across pointer wrap, count steady.
REQ-035 count=5 with push 2 and flush=1 -> next cycle count=0, out_valid=0, in_ready=1; following push appears at head 0.
REQ-036 Entry with in_exception nonzero on slot 1 -> delivered on out_exception bit-exact with its PC; resetn pulsed mid-stream -> count=0 immediately, out_valid=0.
